// File: rtl/ttl74x40103_down_counter.sv
// Presettable synchronous binary down counter with borrow-chain terminal count,
// optional auto-reload and a sticky underflow flag. Define TTL74X40103_OE_EN to add OE_n.
module ttl74x40103_down_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             CLR,
   input  logic             PE_n,
   input  logic [WIDTH-1:0] D,
   input  logic             TE_n,
   input  logic             RELOAD,
   input  logic             DONE_CLR,
`ifdef TTL74X40103_OE_EN
   input  logic             OE_n,
`endif
   output logic [WIDTH-1:0] Q,
   output logic             TC_n,
   output logic             DONE
);

   logic [WIDTH-1:0] count_reg, count_next;
   logic             done_reg, done_next;
   logic             count_zero;
   logic             underflow;

   assign count_zero = (count_reg == '0);

   // Only a non-reload step through zero counts as an underflow; loads never do.
   assign underflow = PE_n && !TE_n && count_zero && !RELOAD;

   always_comb begin
      count_next = count_reg;
      done_next  = done_reg;
      if (!PE_n) begin
         count_next = D;
      end else if (!TE_n) begin
         if (!count_zero)
            count_next = count_reg - WIDTH'(1);
         else if (RELOAD)
            count_next = D;
         else
            count_next = '1;
      end
      // A set on the same edge as DONE_CLR wins so no underflow is lost.
      if (underflow)
         done_next = 1'b1;
      else if (DONE_CLR)
         done_next = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (CLR) begin
         count_reg <= '0;
         done_reg  <= 1'b0;
      end else begin
         count_reg <= count_next;
         done_reg  <= done_next;
      end
   end

   // Borrow out is gated by the live enable so ripple cascades only borrow when enabled.
   assign TC_n = !(count_zero && !TE_n);
   assign DONE = done_reg;

`ifdef TTL74X40103_OE_EN
   assign Q = OE_n ? {WIDTH{1'bz}} : count_reg;
`else
   assign Q = count_reg;
`endif

endmodule

// File: tb/tb_ttl74x40103_down_counter.sv
// Bench for ttl74x40103_down_counter: single 8-bit stage plus a two-stage 16-bit cascade,
// checked every cycle against an arithmetic model and by directed literal expectations.
module tb_ttl74x40103_down_counter;

   logic       clk = 1'b0;
   logic       clr = 1'b0, pe_n = 1'b1, te_n = 1'b1, reload = 1'b0, done_clr = 1'b0;
   logic [7:0] d = 8'h00;
   logic [7:0] q;
   logic       tc_n, done;

   logic        c_clr = 1'b0, c_pe_n = 1'b1, c_te_n = 1'b1;
   logic [15:0] c_d = 16'h0000;
   logic [7:0]  lo_q, hi_q;
   logic        lo_tc_n, hi_tc_n, lo_done, hi_done;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ttl74x40103_down_counter #(.WIDTH(8)) dut (
      .clk(clk), .CLR(clr), .PE_n(pe_n), .D(d), .TE_n(te_n), .RELOAD(reload),
      .DONE_CLR(done_clr), .Q(q), .TC_n(tc_n), .DONE(done)
   );

   ttl74x40103_down_counter #(.WIDTH(8)) lo_stage (
      .clk(clk), .CLR(c_clr), .PE_n(c_pe_n), .D(c_d[7:0]), .TE_n(c_te_n), .RELOAD(1'b0),
      .DONE_CLR(1'b0), .Q(lo_q), .TC_n(lo_tc_n), .DONE(lo_done)
   );

   ttl74x40103_down_counter #(.WIDTH(8)) hi_stage (
      .clk(clk), .CLR(c_clr), .PE_n(c_pe_n), .D(c_d[15:8]), .TE_n(lo_tc_n), .RELOAD(1'b0),
      .DONE_CLR(1'b0), .Q(hi_q), .TC_n(hi_tc_n), .DONE(hi_done)
   );

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Behavioural model: plain modular arithmetic on integers.
   int m_cnt = 0, m_wide = 0;
   bit m_done = 0, m_hi_done = 0, m_valid = 0, c_valid = 0;

   always @(posedge clk) begin
      bit set;
      if (clr) begin
         m_cnt = 0; m_done = 0; m_valid = 1;
      end else begin
         set = 0;
         if (!pe_n) m_cnt = d;
         else if (!te_n) begin
            if (m_cnt == 0 && reload) m_cnt = d;
            else begin
               set = (m_cnt == 0);
               m_cnt = (m_cnt + 255) % 256;
            end
         end
         if (set) m_done = 1;
         else if (done_clr) m_done = 0;
      end
      if (c_clr) begin
         m_wide = 0; m_hi_done = 0; c_valid = 1;
      end else if (!c_pe_n) m_wide = c_d;
      else if (!c_te_n) begin
         if (m_wide == 0) m_hi_done = 1;
         m_wide = (m_wide + 65535) % 65536;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("cyc_q", q, m_cnt);
         chk("cyc_done", done, m_done);
         chk("cyc_tc_n", tc_n, (m_cnt == 0 && !te_n) ? 0 : 1);
      end
      if (c_valid) begin
         chk("cyc_wide_q", {hi_q, lo_q}, m_wide);
         chk("cyc_hi_done", hi_done, m_hi_done);
         chk("cyc_hi_tc_n", hi_tc_n, (m_wide == 0 && !c_te_n) ? 0 : 1);
      end
   end

   task automatic drive(input logic a_clr, input logic a_pe_n, input logic [7:0] a_d,
                        input logic a_te_n, input logic a_reload, input logic a_done_clr);
      @(negedge clk); #1;
      clr = a_clr; pe_n = a_pe_n; d = a_d; te_n = a_te_n; reload = a_reload; done_clr = a_done_clr;
   endtask

   task automatic edge_wait;
      @(posedge clk); #1;
   endtask

   int tc_lows;
   logic [7:0] wrap_seq [4] = '{8'h02, 8'h01, 8'h00, 8'hFF};

   initial begin
      // Reset beats load and count
      drive(1, 0, 8'h55, 0, 0, 0);
      c_clr = 1;
      edge_wait;
      chk("rst_q", q, 8'h00);
      chk("rst_done", done, 0);
      chk("rst_tc_n_low", tc_n, 0);
      te_n = 1; #1;
      chk("rst_tc_n_high", tc_n, 1);
      drive(0, 1, 8'h00, 1, 0, 0);
      c_clr = 0;
      edge_wait;
      $display("reset priority done q=%0h", q);

      // Wrap without reload
      drive(0, 0, 8'h03, 1, 0, 0); edge_wait;
      chk("load_03", q, 8'h03);
      drive(0, 1, 8'h03, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         edge_wait;
         chk("wrap_q", q, wrap_seq[i]);
         chk("wrap_done", done, (i == 3) ? 1 : 0);
         $display("wrap step %0d q=%0h done=%0b", i, q, done);
      end
      drive(0, 1, 8'h00, 1, 0, 0); edge_wait; edge_wait;
      chk("done_sticky", done, 1);
      drive(0, 1, 8'h00, 1, 0, 1); edge_wait;
      chk("done_cleared", done, 0);

      // Auto-reload divide by 5
      drive(0, 0, 8'h04, 1, 1, 0); edge_wait;
      chk("load_04", q, 8'h04);
      drive(0, 1, 8'h04, 0, 1, 0);
      tc_lows = 0;
      for (int i = 0; i < 10; i++) begin
         edge_wait;
         chk("div_q", q, 4 - ((i + 1) % 5));
         if (!tc_n) tc_lows++;
         $display("divider step %0d q=%0h tc_n=%0b", i, q, tc_n);
      end
      chk("div_tc_lows", tc_lows, 2);
      chk("div_done", done, 0);

      // Hold and enable gating
      drive(0, 0, 8'h10, 1, 1, 0); edge_wait;
      drive(0, 1, 8'h10, 1, 1, 0);
      for (int i = 0; i < 10; i++) edge_wait;
      chk("hold_q", q, 8'h10);
      drive(0, 0, 8'h00, 1, 1, 0); edge_wait;
      chk("load_00_tc_n", tc_n, 1);
      pe_n = 1; te_n = 0; #1;
      chk("te_to_tc_n", tc_n, 0);
      edge_wait;
      chk("reload_d0_q", q, 8'h00);
      $display("hold/gating done q=%0h", q);

      // Load beats count at zero
      drive(0, 0, 8'hA7, 0, 0, 0); edge_wait;
      chk("collision_q", q, 8'hA7);
      chk("collision_done", done, 0);

      // DONE_CLR loses to a simultaneous underflow
      drive(0, 0, 8'h00, 1, 0, 0); edge_wait;
      drive(0, 1, 8'h00, 0, 0, 1); edge_wait;
      chk("set_wins_q", q, 8'hFF);
      chk("set_wins_done", done, 1);

      // Clear mid-count
      drive(0, 1, 8'h00, 0, 0, 0); edge_wait;
      drive(1, 1, 8'h00, 0, 0, 0); edge_wait;
      chk("midclr_q", q, 8'h00);
      chk("midclr_done", done, 0);
      drive(0, 1, 8'h00, 1, 0, 0); edge_wait;

      // Two-stage cascade
      @(negedge clk); #1;
      c_pe_n = 0; c_d = 16'h0100; c_te_n = 1;
      edge_wait;
      @(negedge clk); #1;
      c_pe_n = 1; c_te_n = 0;
      edge_wait;
      chk("casc_00ff", {hi_q, lo_q}, 16'h00FF);
      chk("casc_hi_done0", hi_done, 0);
      $display("cascade step q=%0h", {hi_q, lo_q});
      @(negedge clk); #1;
      c_pe_n = 0; c_d = 16'h0000; c_te_n = 1;
      edge_wait;
      @(negedge clk); #1;
      c_pe_n = 1; c_te_n = 0;
      edge_wait;
      chk("casc_ffff", {hi_q, lo_q}, 16'hFFFF);
      chk("casc_hi_done1", hi_done, 1);
      $display("cascade wrap q=%0h hi_done=%0b", {hi_q, lo_q}, hi_done);
      @(negedge clk); #1;
      c_te_n = 1;
      edge_wait;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
